vga_symbol_overlay: RTL
=======================

# vga_symbol_overlay

Parametrised overlay that draws font-ROM glyphs (time-separator colons, date slashes, any other symbol) at run-time-configurable screen positions on the VGA pixel stream. It is the successor of the fixed-position separator printer: multiple slots, per-slot colour, integer scaling and frame-counted blinking. It sits between the VGA sync generator and the final RGB multiplexer, in parallel with the digit renderers. It drives a synchronous font ROM through an address/data port.

## Interface
Parameters:
- NUM_SLOTS, 4: number of independent symbol slots (1..8)
- GLYPH_BITS, 4: glyph index width; the ROM holds 2^GLYPH_BITS glyphs of 16 rows × 8 columns
- X_SHIFT, 0: horizontal scale; each glyph column is 2^X_SHIFT pixels wide
- Y_SHIFT, 2: vertical scale; each glyph row is 2^Y_SHIFT pixels tall
- BLINK_FRAMES, 30: frame_start pulses per blink half-period

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high; clears all state
- okmaquina  in  1  render enable; 0 forces transparent output
- video_on  in  1  active-video flag, aligned with pix_x/pix_y
- pix_x, pix_y  in  10 each  current pixel coordinates
- frame_start  in  1  one-cycle pulse per frame
- cfg_we  in  1  slot register write strobe
- cfg_slot  in  3  slot index; writes to index ≥ NUM_SLOTS are ignored
- cfg_en  in  1  slot enable
- cfg_blink  in  1  slot blinks when 1
- cfg_x, cfg_y  in  10 each  top-left corner of the slot
- cfg_glyph  in  GLYPH_BITS  glyph index
- cfg_rgb  in  12  foreground colour
- rom_addr  out  GLYPH_BITS+4  {glyph, row}; registered
- rom_data  in  8  glyph row; bit 7 is the leftmost pixel; valid one cycle after rom_addr
- rgbtext  out  12  pixel colour; 0 when no symbol pixel is lit
- symbol_on  out  1  1 when rgbtext carries a lit symbol pixel

## Operation
- Slot register file: NUM_SLOTS entries of {en, blink, x, y, glyph, rgb}. An entry is written on the clk edge where cfg_we=1. Reset values: en=0, blink=0, x=y=0, glyph=0, rgb=12'h0ff.
- Blink generator:
  - An 8-bit frame counter increments on each frame_start pulse.
  - When the counter equals BLINK_FRAMES-1 and frame_start=1, the counter returns to 0 and blink_phase toggles.
  - Reset: counter=0, blink_phase=0.
  - The generator runs regardless of okmaquina.
- Slot hit conditions, all required:
  - en=1
  - not (blink=1 and blink_phase=1)
  - 0 ≤ pix_x−x < 8<<X_SHIFT
  - 0 ≤ pix_y−y < 16<<Y_SHIFT
  - Comparisons are done in 11-bit unsigned arithmetic, so a region that extends past 1023 never wraps onto column or row 0.
- Priority: the lowest-indexed hit slot wins. A blinked-off slot is skipped, so the next hit slot shows through.
- Coordinate mapping: row = (pix_y−y)>>Y_SHIFT (4 bits); col = (pix_x−x)>>X_SHIFT (3 bits).
- Pipeline:
  - S1 (edge 1) registers rom_addr={glyph,row}, col, hit, rgb, video_on and okmaquina.
  - S2 (edge 2) carries these fields forward while the ROM returns rom_data.
  - S3 (edge 3) selects bit rom_data[7−col]. It sets symbol_on = hit & bit & video_on & okmaquina, and rgbtext = symbol_on ? rgb : 0.
- When there is no hit, rom_addr holds its previous value and the output is 0.

## Timing
- Latency: pixel presented in cycle n produces rgbtext/symbol_on in cycle n+3. The sync generator must delay hsync/vsync by 3 cycles.
- Throughput: one pixel per clock; no stalls.
- Config write in cycle n affects pixels presented in cycle n+1 onward. A write to the slot currently being drawn takes effect mid-frame; no shadowing.
- A frame_start pulse that toggles blink_phase in cycle n affects pixels presented from cycle n+1.
- Asynchronous reset, taking effect immediately:
  - rgbtext=0, symbol_on=0, rom_addr=0
  - all pipeline valid/hit flags cleared
  - slot registers and blink generator reset
- Reset asserted mid-line: output is 0 until 3 cycles after reset deasserts.
- okmaquina and video_on are pipelined with the pixel, so toggling either affects exactly the pixels presented with it.

## Test plan
- Colon slot:
  - Stimulus: write slot0 {en=1, x=280, y=64, glyph=6, rgb=12'h0ff}; model ROM glyph 6 row 0 = 8'h18; sweep pix_y=64, pix_x=280..287.
  - Required response: rgbtext=12'h0ff exactly at x=283,284, with 3-cycle latency; all other pixels 0. With Y_SHIFT=2, pix_y=64..67 all read row 0; pix_y=68 reads row 1.
- Priority and blink:
  - Stimulus: slot0 and slot1 overlap at (256,192), slot0 blink=1, BLINK_FRAMES=2; 2 frame_start pulses toggle blink_phase.
  - Required response: before the toggle, the slot0 colour is shown. After the toggle, the slot1 colour is shown. After 2 more pulses, the slot0 colour returns.
- Boundaries:
  - Stimulus: slot at x=1020, y=0.
  - Required response: pix_x=1023 hits at col 3; pix_x=0 does not hit. pix_y=63 hits at row 15; pix_y=64 misses.
- Gating:
  - Stimulus: video_on=0 or okmaquina=0 on an otherwise lit pixel.
  - Required response: rgbtext=0 and symbol_on=0 for exactly that pixel, 3 cycles later.
- Ignored write:
  - Stimulus: cfg_we with cfg_slot=5 when NUM_SLOTS=4.
  - Required response: no slot changes.
- Reset:
  - Stimulus: reset pulsed mid-line while a slot is drawing.
  - Required response: outputs go to 0 immediately; after release, nothing is drawn until the slot is reprogrammed, because en was cleared.

Source files
------------

// File: rtl/vga_symbol_overlay.sv
// ============================================================================
// vga_symbol_overlay
//
// Draws font-ROM glyphs at run-time-configurable screen positions on the VGA
// pixel stream. Each slot has its own position, glyph, colour, and blink
// control. Glyphs can be scaled by powers of two.
//
// The overlay has three pipeline stages:
//   S1 : slot hit detection and priority selection; registers the ROM address
//   S2 : waits for the synchronous font ROM to return the glyph row
//   S3 : picks the glyph column bit and produces the output colour
// A pixel presented in cycle n appears on rgbtext/symbol_on in cycle n+3.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   okmaquina           render enable (0 = transparent)
//   video_on            active-video flag aligned with pix_x/pix_y
//   pix_x, pix_y        current pixel coordinates
//   frame_start         one-cycle pulse per frame (drives the blink timer)
//   cfg_*               slot register write port (cfg_we strobe)
//   rom_addr/rom_data   synchronous font ROM port, {glyph,row} -> 8-bit row
//   rgbtext, symbol_on  overlay colour and lit-pixel flag
// ============================================================================
module vga_symbol_overlay #(
    parameter int NUM_SLOTS    = 4,
    parameter int GLYPH_BITS   = 4,
    parameter int X_SHIFT      = 0,
    parameter int Y_SHIFT      = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  okmaquina,
    input  logic                  video_on,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  frame_start,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_slot,
    input  logic                  cfg_en,
    input  logic                  cfg_blink,
    input  logic [9:0]            cfg_x,
    input  logic [9:0]            cfg_y,
    input  logic [GLYPH_BITS-1:0] cfg_glyph,
    input  logic [11:0]           cfg_rgb,
    output logic [GLYPH_BITS+3:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [11:0]           rgbtext,
    output logic                  symbol_on
);

    // Glyph footprint on screen, in pixels. These widths match the 11-bit
    // offset arithmetic below.
    localparam logic [10:0] GLYPH_W = 11'(8 << X_SHIFT);
    localparam logic [10:0] GLYPH_H = 11'(16 << Y_SHIFT);

    // ------------------------------------------------------------------
    // Blink generator: the phase toggles every BLINK_FRAMES frame pulses.
    // It runs independently of okmaquina.
    // ------------------------------------------------------------------
    logic [7:0] frame_cnt_reg;
    logic       blink_phase_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg   <= 8'd0;
            blink_phase_reg <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_reg == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt_reg   <= 8'd0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot register file and per-slot hit detection
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0]  hit_vec;
    logic [3:0]            slot_row   [NUM_SLOTS];
    logic [2:0]            slot_col   [NUM_SLOTS];
    logic [GLYPH_BITS-1:0] slot_glyph [NUM_SLOTS];
    logic [11:0]           slot_rgb   [NUM_SLOTS];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic                  en_reg;
            logic                  blink_reg;
            logic [9:0]            x_reg;
            logic [9:0]            y_reg;
            logic [GLYPH_BITS-1:0] glyph_reg;
            logic [11:0]           rgb_reg;

            // Slot indices at or above NUM_SLOTS match no generated slot,
            // so writes to them are ignored.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    en_reg    <= 1'b0;
                    blink_reg <= 1'b0;
                    x_reg     <= 10'd0;
                    y_reg     <= 10'd0;
                    glyph_reg <= '0;
                    rgb_reg   <= 12'h0ff;
                end else if (cfg_we && (cfg_slot == 3'(gi))) begin
                    en_reg    <= cfg_en;
                    blink_reg <= cfg_blink;
                    x_reg     <= cfg_x;
                    y_reg     <= cfg_y;
                    glyph_reg <= cfg_glyph;
                    rgb_reg   <= cfg_rgb;
                end
            end

            // Offsets use 11-bit arithmetic. A slot near the right or bottom
            // edge therefore extends past 1023 instead of wrapping onto
            // column or row 0. The explicit >= guards reject pixels that lie
            // before the slot corner.
            logic [10:0] dx;
            logic [10:0] dy;
            logic        x_in;
            logic        y_in;

            assign dx   = {1'b0, pix_x} - {1'b0, x_reg};
            assign dy   = {1'b0, pix_y} - {1'b0, y_reg};
            assign x_in = (pix_x >= x_reg) && (dx < GLYPH_W);
            assign y_in = (pix_y >= y_reg) && (dy < GLYPH_H);

            // A blinked-off slot is not a hit, so a lower-priority slot
            // underneath can show through.
            assign hit_vec[gi]    = en_reg && !(blink_reg && blink_phase_reg) && x_in && y_in;
            assign slot_row[gi]   = dy[Y_SHIFT +: 4];
            assign slot_col[gi]   = dx[X_SHIFT +: 3];
            assign slot_glyph[gi] = glyph_reg;
            assign slot_rgb[gi]   = rgb_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority select: the lowest-indexed hit slot wins. The loop scans
    // downward so that the last assignment comes from the lowest index.
    // ------------------------------------------------------------------
    logic                  sel_hit;
    logic [GLYPH_BITS-1:0] sel_glyph;
    logic [3:0]            sel_row;
    logic [2:0]            sel_col;
    logic [11:0]           sel_rgb;

    always_comb begin
        sel_hit   = 1'b0;
        sel_glyph = '0;
        sel_row   = 4'd0;
        sel_col   = 3'd0;
        sel_rgb   = 12'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel_hit   = 1'b1;
                sel_glyph = slot_glyph[i];
                sel_row   = slot_row[i];
                sel_col   = slot_col[i];
                sel_rgb   = slot_rgb[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: register the ROM address and the per-pixel attributes.
    // ------------------------------------------------------------------
    logic [GLYPH_BITS+3:0] rom_addr_reg;
    logic [2:0]            col_s1_reg;
    logic                  hit_s1_reg;
    logic [11:0]           rgb_s1_reg;
    logic                  vid_s1_reg;
    logic                  ok_s1_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_reg <= '0;
            col_s1_reg   <= 3'd0;
            hit_s1_reg   <= 1'b0;
            rgb_s1_reg   <= 12'd0;
            vid_s1_reg   <= 1'b0;
            ok_s1_reg    <= 1'b0;
        end else begin
            // When no slot is hit, the address holds its previous value to
            // avoid needless ROM toggling. The hit flag masks the output.
            if (sel_hit) begin
                rom_addr_reg <= {sel_glyph, sel_row};
            end
            col_s1_reg <= sel_col;
            hit_s1_reg <= sel_hit;
            rgb_s1_reg <= sel_rgb;
            vid_s1_reg <= video_on;
            ok_s1_reg  <= okmaquina;
        end
    end

    assign rom_addr = rom_addr_reg;

    // ------------------------------------------------------------------
    // S2: carry the attributes forward while the ROM returns the row data.
    // ------------------------------------------------------------------
    logic [2:0]  col_s2_reg;
    logic        hit_s2_reg;
    logic [11:0] rgb_s2_reg;
    logic        vid_s2_reg;
    logic        ok_s2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_s2_reg <= 3'd0;
            hit_s2_reg <= 1'b0;
            rgb_s2_reg <= 12'd0;
            vid_s2_reg <= 1'b0;
            ok_s2_reg  <= 1'b0;
        end else begin
            col_s2_reg <= col_s1_reg;
            hit_s2_reg <= hit_s1_reg;
            rgb_s2_reg <= rgb_s1_reg;
            vid_s2_reg <= vid_s1_reg;
            ok_s2_reg  <= ok_s1_reg;
        end
    end

    // ------------------------------------------------------------------
    // S3: pick the glyph column (bit 7 is the leftmost pixel) and gate it
    // with the hit, video_on, and okmaquina flags.
    // ------------------------------------------------------------------
    logic        pix_bit;
    logic        lit_next;
    logic [11:0] rgbtext_reg;
    logic        symbol_on_reg;

    assign pix_bit  = rom_data[3'd7 - col_s2_reg];
    assign lit_next = hit_s2_reg && pix_bit && vid_s2_reg && ok_s2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgbtext_reg   <= 12'd0;
            symbol_on_reg <= 1'b0;
        end else begin
            symbol_on_reg <= lit_next;
            rgbtext_reg   <= lit_next ? rgb_s2_reg : 12'd0;
        end
    end

    assign rgbtext   = rgbtext_reg;
    assign symbol_on = symbol_on_reg;

endmodule
